// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side and execute-side signals of the ID/EX pipeline register.
interface id_ex_stage_if #(
    parameter int WIDTH = 32
);
    logic             Stall;
    logic             Flush;
    logic             ValidIn;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic [WIDTH-1:0] Imm32;
    logic [4:0]       Rs;
    logic [4:0]       Rt;
    logic [4:0]       Rw_in;
    logic             ALUSrc_in;
    logic [2:0]       ALUctr_in;
    logic             RegWr_in;
    logic             ExMem_RegWr;
    logic [4:0]       ExMem_Rw;
    logic [WIDTH-1:0] ExMem_Result;
    logic             MemWb_RegWr;
    logic [4:0]       MemWb_Rw;
    logic [WIDTH-1:0] MemWb_Data;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] StoreData;
    logic [2:0]       ALUctr;
    logic [4:0]       Rw_out;
    logic             RegWr_out;
    logic             ValidOut;

    modport master (
        output Stall, Flush, ValidIn, busA, busB, Imm32, Rs, Rt, Rw_in,
               ALUSrc_in, ALUctr_in, RegWr_in,
               ExMem_RegWr, ExMem_Rw, ExMem_Result,
               MemWb_RegWr, MemWb_Rw, MemWb_Data,
        input  A, B, StoreData, ALUctr, Rw_out, RegWr_out, ValidOut
    );

    modport slave (
        input  Stall, Flush, ValidIn, busA, busB, Imm32, Rs, Rt, Rw_in,
               ALUSrc_in, ALUctr_in, RegWr_in,
               ExMem_RegWr, ExMem_Rw, ExMem_Result,
               MemWb_RegWr, MemWb_Rw, MemWb_Data,
        output A, B, StoreData, ALUctr, Rw_out, RegWr_out, ValidOut
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall, flush and operand forwarding.
// Define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding onto A, B and StoreData.
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    id_ex_stage_if.slave bus
);
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, imm_q, imm_d;
    logic [4:0]       rs_q, rs_d, rt_q, rt_d, rw_q, rw_d;
    logic [2:0]       aluctr_q, aluctr_d;
    logic             alusrc_q, alusrc_d, regwr_q, regwr_d, valid_q, valid_d;
    logic [WIDTH-1:0] fwd_a, fwd_b;

`ifdef ID_EX_FORWARD_EN
    logic ex_a, ex_b, wb_a, wb_b;
    // Pick the youngest producer of each stored source register; r0 is never forwarded.
    always_comb begin
        ex_a  = bus.ExMem_RegWr && (bus.ExMem_Rw == rs_q) && (rs_q != 5'd0);
        ex_b  = bus.ExMem_RegWr && (bus.ExMem_Rw == rt_q) && (rt_q != 5'd0);
        wb_a  = bus.MemWb_RegWr && (bus.MemWb_Rw == rs_q) && (rs_q != 5'd0);
        wb_b  = bus.MemWb_RegWr && (bus.MemWb_Rw == rt_q) && (rt_q != 5'd0);
        fwd_a = ex_a ? bus.ExMem_Result : wb_a ? bus.MemWb_Data : opa_q;
        fwd_b = ex_b ? bus.ExMem_Result : wb_b ? bus.MemWb_Data : opb_q;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.ExMem_RegWr, bus.ExMem_Rw, bus.ExMem_Result,
                          bus.MemWb_RegWr, bus.MemWb_Rw, bus.MemWb_Data, rs_q, rt_q};
    // Without forwarding the stored operands are used as-is.
    always_comb begin
        fwd_a = opa_q;
        fwd_b = opb_q;
    end
`endif

    // Next entry: flush inserts a bubble, stall keeps the entry but refreshes operands, else load decode.
    always_comb begin
        opa_d    = bus.busA;
        opb_d    = bus.busB;
        imm_d    = bus.Imm32;
        rs_d     = bus.Rs;
        rt_d     = bus.Rt;
        rw_d     = bus.Rw_in;
        alusrc_d = bus.ALUSrc_in;
        aluctr_d = bus.ALUctr_in;
        regwr_d  = bus.RegWr_in;
        valid_d  = bus.ValidIn;
        if (bus.Flush) begin
            opa_d    = '0;
            opb_d    = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            rw_d     = '0;
            alusrc_d = 1'b0;
            aluctr_d = '0;
            regwr_d  = 1'b0;
            valid_d  = 1'b0;
        end else if (bus.Stall) begin
            opa_d    = fwd_a;
            opb_d    = fwd_b;
            imm_d    = imm_q;
            rs_d     = rs_q;
            rt_d     = rt_q;
            rw_d     = rw_q;
            alusrc_d = alusrc_q;
            aluctr_d = aluctr_q;
            regwr_d  = regwr_q;
            valid_d  = valid_q;
        end
    end

    // Stage register; reset loads the same bubble as a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rw_q     <= '0;
            alusrc_q <= 1'b0;
            aluctr_q <= '0;
            regwr_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rw_q     <= rw_d;
            alusrc_q <= alusrc_d;
            aluctr_q <= aluctr_d;
            regwr_q  <= regwr_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.A         = fwd_a;
    assign bus.B         = alusrc_q ? imm_q : fwd_b;
    assign bus.StoreData = fwd_b;
    assign bus.ALUctr    = aluctr_q;
    assign bus.Rw_out    = rw_q;
    assign bus.RegWr_out = regwr_q & valid_q;
    assign bus.ValidOut  = valid_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, forwarding corner sequences and a randomized model comparison.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_if #(.WIDTH(32)) bus ();
    id_ex_stage #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, flush, vin;
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, rw;
        logic        src;
        logic [2:0]  ctr;
        logic        rwr;
        logic [31:0] ea, eb, esd;
        logic [2:0]  ectr;
        logic [4:0]  erw;
        logic        erwo, ev;
    } vec_t;

    typedef struct {
        logic [31:0] opa, opb, imm;
        logic [4:0]  rs, rt, rw;
        logic        src;
        logic [2:0]  ctr;
        logic        rwr, v;
    } ent_t;

    vec_t vt[11];
    ent_t m, m_n;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [105:0] dut_out();
        return {bus.A, bus.B, bus.StoreData, bus.ALUctr, bus.Rw_out, bus.RegWr_out, bus.ValidOut};
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] stored);
        if (FWD && r != 0 && bus.ExMem_RegWr && bus.ExMem_Rw == r) return bus.ExMem_Result;
        if (FWD && r != 0 && bus.MemWb_RegWr && bus.MemWb_Rw == r) return bus.MemWb_Data;
        return stored;
    endfunction

    function automatic ent_t step(input ent_t e);
        ent_t n;
        n = '{default: '0};
        if (rst || bus.Flush) return n;
        if (bus.Stall) begin
            n     = e;
            n.opa = fwd(e.rs, e.opa);
            n.opb = fwd(e.rt, e.opb);
            return n;
        end
        n.opa = bus.busA;  n.opb = bus.busB;  n.imm = bus.Imm32;
        n.rs  = bus.Rs;    n.rt  = bus.Rt;    n.rw  = bus.Rw_in;
        n.src = bus.ALUSrc_in; n.ctr = bus.ALUctr_in;
        n.rwr = bus.RegWr_in;  n.v   = bus.ValidIn;
        return n;
    endfunction

    function automatic logic [105:0] model_out(input ent_t e);
        logic [31:0] fb;
        fb = fwd(e.rt, e.opb);
        return {fwd(e.rs, e.opa), e.src ? e.imm : fb, fb, e.ctr, e.rw, e.rwr & e.v, e.v};
    endfunction

    task automatic drive(input logic vin, input logic [31:0] a, b, imm, input logic [4:0] rs, rt, rw,
                         input logic src, input logic [2:0] ctr, input logic rwr);
        bus.ValidIn = vin; bus.busA = a; bus.busB = b; bus.Imm32 = imm;
        bus.Rs = rs; bus.Rt = rt; bus.Rw_in = rw;
        bus.ALUSrc_in = src; bus.ALUctr_in = ctr; bus.RegWr_in = rwr;
    endtask

    task automatic clear_fwd();
        bus.ExMem_RegWr = 0; bus.ExMem_Rw = 0; bus.ExMem_Result = 0;
        bus.MemWb_RegWr = 0; bus.MemWb_Rw = 0; bus.MemWb_Data = 0;
    endtask

    initial begin
        bus.Stall = 0; bus.Flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clear_fwd();
        //        rst st fl vin a             b             imm           rs rt rw  src ctr rwr | A             B             SD            ctr rw  rwo v
        vt[0]  = '{1, 0, 0, 1, 32'h1,        32'h2,        32'h3,        1, 2, 3,  0, 3'd6, 1, 32'h0,        32'h0,        32'h0,        3'd0, 0,  0, 0};
        vt[1]  = '{0, 0, 0, 1, 32'h5,        32'h7,        32'h0,        1, 2, 3,  0, 3'd4, 1, 32'h5,        32'h7,        32'h7,        3'd4, 3,  1, 1};
        vt[2]  = '{0, 1, 0, 1, 32'h9,        32'h9,        32'h9,        5, 6, 8,  1, 3'd1, 0, 32'h5,        32'h7,        32'h7,        3'd4, 3,  1, 1};
        vt[3]  = '{0, 0, 0, 1, 32'h10,       32'h20,       32'hFFFFFFFC, 1, 2, 5,  1, 3'd2, 1, 32'h10,       32'hFFFFFFFC, 32'h20,       3'd2, 5,  1, 1};
        vt[4]  = '{0, 1, 1, 1, 32'h44,       32'h45,       32'h46,       1, 2, 7,  0, 3'd3, 1, 32'h0,        32'h0,        32'h0,        3'd0, 0,  0, 0};
        vt[5]  = '{0, 0, 0, 1, 32'hAAAA5555, 32'h1234,     32'h0,        1, 2, 31, 0, 3'd7, 0, 32'hAAAA5555, 32'h1234,     32'h1234,     3'd7, 31, 0, 1};
        vt[6]  = '{0, 0, 0, 0, 32'h3,        32'h4,        32'h8,        1, 2, 2,  0, 3'd3, 1, 32'h3,        32'h4,        32'h4,        3'd3, 2,  0, 0};
        vt[7]  = '{0, 0, 0, 1, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1, 2, 9,  0, 3'd5, 1, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 3'd5, 9,  1, 1};
        vt[8]  = '{1, 1, 0, 1, 32'h77,       32'h78,       32'h79,       1, 2, 4,  0, 3'd2, 1, 32'h0,        32'h0,        32'h0,        3'd0, 0,  0, 0};
        vt[9]  = '{0, 0, 0, 1, 32'hC0,       32'hC1,       32'hC2,       1, 2, 12, 1, 3'd1, 1, 32'hC0,       32'hC2,       32'hC1,       3'd1, 12, 1, 1};
        vt[10] = '{0, 0, 1, 1, 32'hD0,       32'hD1,       32'hD2,       1, 2, 13, 0, 3'd6, 1, 32'h0,        32'h0,        32'h0,        3'd0, 0,  0, 0};

        for (int i = 0; i < 11; i++) begin
            rst = vt[i].rst; bus.Stall = vt[i].stall; bus.Flush = vt[i].flush;
            drive(vt[i].vin, vt[i].a, vt[i].b, vt[i].imm, vt[i].rs, vt[i].rt, vt[i].rw,
                  vt[i].src, vt[i].ctr, vt[i].rwr);
            @(posedge clk); #1;
            rst = 0;
            check($sformatf("vec%0d", i), dut_out(),
                  {vt[i].ea, vt[i].eb, vt[i].esd, vt[i].ectr, vt[i].erw, vt[i].erwo, vt[i].ev});
        end
        bus.Stall = 0; bus.Flush = 0;

        // Forward priority on A.
        drive(1, 32'h55, 32'h0, 32'h0, 3, 0, 1, 0, 0, 1);
        @(posedge clk); #1;
        bus.ExMem_RegWr = 1; bus.ExMem_Rw = 3; bus.ExMem_Result = 32'h11;
        bus.MemWb_RegWr = 1; bus.MemWb_Rw = 3; bus.MemWb_Data = 32'h22;
        bus.Stall = 1;
        #1 check("fwd_both", bus.A, FWD ? 32'h11 : 32'h55);
        bus.ExMem_RegWr = 0;
        #1 check("fwd_memwb", bus.A, FWD ? 32'h22 : 32'h55);
        bus.Stall = 0; clear_fwd();
        drive(1, 32'h66, 32'h0, 32'h0, 0, 0, 1, 0, 0, 1);
        @(posedge clk); #1;
        bus.ExMem_RegWr = 1; bus.MemWb_RegWr = 1; bus.ExMem_Result = 32'h11; bus.MemWb_Data = 32'h22;
        #1 check("fwd_r0", bus.A, 32'h66);
        clear_fwd();

        // Forwarded data survives a stall.
        drive(1, 32'h0, 32'h7, 32'h0, 0, 4, 1, 0, 0, 1);
        @(posedge clk); #1;
        bus.MemWb_RegWr = 1; bus.MemWb_Rw = 4; bus.MemWb_Data = 32'h99; bus.Stall = 1;
        @(posedge clk); #1;
        bus.MemWb_RegWr = 0; bus.Stall = 0;
        #1 check("stall_fwd_b", bus.B, FWD ? 32'h99 : 32'h7);
        check("stall_fwd_sd", bus.StoreData, FWD ? 32'h99 : 32'h7);
        clear_fwd();

        // Immediate selects B while StoreData keeps the forwarded Rt.
        drive(1, 32'h0, 32'h1, 32'hFFFFFFFC, 0, 6, 1, 1, 0, 1);
        @(posedge clk); #1;
        bus.ExMem_RegWr = 1; bus.ExMem_Rw = 6; bus.ExMem_Result = 32'h33;
        #1 check("imm_b", bus.B, 32'hFFFFFFFC);
        check("imm_sd", bus.StoreData, FWD ? 32'h33 : 32'h1);
        clear_fwd();

        // Randomized comparison against the reference model.
        m = '{default: '0};
        for (int i = 0; i < 400; i++) begin
            rst = (i == 0) || ($urandom_range(0, 31) == 0);
            bus.Stall = ($urandom_range(0, 3) == 0);
            bus.Flush = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 1), $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 1));
            bus.ExMem_RegWr = $urandom_range(0, 1); bus.ExMem_Rw = 5'($urandom_range(0, 3));
            bus.ExMem_Result = $urandom;
            bus.MemWb_RegWr = $urandom_range(0, 1); bus.MemWb_Rw = 5'($urandom_range(0, 3));
            bus.MemWb_Data = $urandom;
            #1 m_n = step(m);
            @(posedge clk); #1;
            m = m_n;
            check("rand", dut_out(), model_out(m));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and results.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 Stall  in  1  hold stage contents this cycle.
REQ-005 Flush  in  1  replace stage contents with a bubble this cycle.
REQ-006 ValidIn  in  1  decode presents a real instruction.
REQ-007 busA, busB  in  WIDTH  register-file read data for Rs, Rt.
REQ-008 Imm32  in  WIDTH  extended immediate from decode.
REQ-009 Rs, Rt, Rw_in  in  5 each  source and destination register numbers.
REQ-010 ALUSrc_in  in  1  1 selects Imm32 as ALU B operand.
REQ-011 ALUctr_in  in  3  ALU operation code, passed through unchanged.
REQ-012 RegWr_in  in  1  instruction writes Rw_in.
REQ-013 ExMem_RegWr, ExMem_Rw (5), ExMem_Result (WIDTH)  in  forwarding source 1 (instruction one stage ahead).
REQ-014 MemWb_RegWr, MemWb_Rw (5), MemWb_Data (WIDTH)  in  forwarding source 2 (instruction two stages ahead).
REQ-015 A, B  out  WIDTH  ALU operands.
REQ-016 StoreData  out  WIDTH  forwarded Rt value, independent of ALUSrc.
REQ-017 ALUctr  out  3; Rw_out  out  5; RegWr_out  out  1; ValidOut  out  1.

Function
REQ-018 Stage SHALL hold one registered entry: opA, opB, imm, Rs, Rt, Rw, ALUSrc, ALUctr, RegWr, Valid.
REQ-019 Latency one cycle: with Stall=0, Flush=0, inputs sampled at edge N appear on outputs after edge N.
REQ-020 Flush=1 SHALL load a bubble (Valid=0, RegWr=0, ALUctr=000, all data fields 0); Flush SHALL override Stall.
REQ-021 Stall=1, Flush=0 SHALL keep control fields and Rs/Rt/Rw/imm; opA/opB SHALL reload with the current forwarded Rs/Rt values so forwarded data survives the stall.
REQ-022 RegWr_out SHALL equal stored RegWr AND stored Valid.
REQ-023 Forwarding, evaluated combinationally on stored Rs (for A) and Rt (for B/StoreData): ExMem match (ExMem_RegWr=1, ExMem_Rw=reg, reg!=0) selects ExMem_Result; else MemWb match selects MemWb_Data; else stored opA/opB.
REQ-024 Register 0 SHALL never be forwarded; both sources matching SHALL select ExMem.
REQ-025 B SHALL be stored imm when stored ALUSrc=1, else forwarded Rt value; StoreData always forwarded Rt value.
REQ-026 A, B SHALL be driven as described even when Valid=0 (consumer gates on ValidOut).
REQ-027 No arithmetic performed; all data paths exactly WIDTH bits, no extension or truncation.

Reset
REQ-028 rst=1 at an edge SHALL load the bubble of REQ-020; rst overrides Stall and Flush.
REQ-029 After reset: ValidOut=0, RegWr_out=0, ALUctr=000, Rw_out=0, A=B=StoreData=0 absent forwarding matches.
REQ-030 rst asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-031 Macro ID_EX_FORWARD_EN: defined -> forwarding per REQ-021/023/024; undefined -> A=stored opA, B per ALUSrc from stored opB/imm, StoreData=stored opB, stall simply holds all fields, ExMem_*/MemWb_* ignored.

Verification
REQ-032 Reset: rst=1 one cycle -> ValidOut=0, RegWr_out=0, ALUctr=000, A=B=0.
REQ-033 Pass-through: busA=5, busB=7, ALUctr_in=100, ALUSrc_in=0, ValidIn=1 -> next cycle A=5, B=7, ALUctr=100, ValidOut=1.
REQ-034 Forward priority: stored Rs=3, ExMem_Rw=3 Result=0x11, MemWb_Rw=3 Data=0x22, both RegWr=1 -> A=0x11; ExMem_RegWr=0 -> A=0x22; Rs=0 -> A=stored opA.
REQ-035 Stall with forward: Rt=4, MemWb_Rw=4 Data=0x99, Stall=1 one cycle, then MemWb_RegWr=0 -> B stays 0x99 (ID_EX_FORWARD_EN defined).
REQ-036 Flush vs Stall: valid entry held, Stall=1 and Flush=1 same cycle -> ValidOut=0, RegWr_out=0.
REQ-037 Immediate: ALUSrc_in=1, Imm32=0xFFFF_FFFC, Rt forwarded 0x33 -> B=0xFFFF_FFFC, StoreData=0x33.
